// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one registered ALU among NREQ requesters.
// One operation in flight: IDLE accepts, ISSUE pulses alu_run, CAPTURE samples the result, RESP hands it back.
module alu_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3,
  parameter int NREQ  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  input  logic [NREQ*SELW-1:0]   req_sel,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [SELW-1:0]        alu_select,
  output logic                   alu_run,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic [SELW-1:0]   sel_q;
  logic              run_q;

  logic              found;
  logic [PW-1:0]     win;

  // NOTE: every variable assigned in always_comb gets a default on entry,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin : arbiter
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

  // Reset is gated in so no accept strobe can appear while rst is held.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && !rst && found) req_ready[win] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP) resp_valid[grant_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            a_q     <= req_a[win*WIDTH +: WIDTH];
            b_q     <= req_b[win*WIDTH +: WIDTH];
            sel_q   <= req_sel[win*SELW +: SELW];
            grant_q <= win;
            ptr_q   <= ptr_d;
            run_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          run_q   <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res_q   <= alu_result;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[grant_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = sel_q;
  assign alu_run    = run_q;
  assign resp_data  = res_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a protocol-level model predicts grants and timing,
// a monitor compares every presented response against the queued expectation.
module tb_alu_rr_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 16;
  localparam int SW   = 3;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sel;
  } op_t;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_a = '0;
  logic [NREQ*W-1:0]  req_b = '0;
  logic [NREQ*SW-1:0] req_sel = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready = '1;
  logic [W-1:0]       resp_data;
  logic [W-1:0]       alu_a, alu_b;
  logic [SW-1:0]      alu_select;
  logic               alu_run;
  logic [W-1:0]       alu_result = '0;
  logic               busy;

  alu_rr_scheduler #(.WIDTH(W), .SELW(SW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_run(alu_run),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [SW-1:0] sel);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return (a > b) ? 16'd1 : ((a < b) ? 16'd2 : 16'd0);
    endcase
  endfunction

  // Shared ALU: result registered one edge after run.
  always @(posedge clk) if (alu_run) alu_result <= alu_ref(alu_a, alu_b, alu_select);

  exp_t exp_q[$];
  int   obs_idx[$];
  logic [W-1:0] obs_data[$];
  int   cnt_log[$];

  // Reference model: phase 0 free, 1 issue, 2 capture, 3 response pending.
  int  m_phase = 0;
  int  m_ptr   = 0;
  int  m_grant = 0;
  op_t m_op;
  int  m_pick;
  logic [NREQ-1:0] m_ready;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      m_pick  = -1;
      m_ready = '0;
      if (m_phase == 0)
        for (int k = 0; k < NREQ; k++)
          if (m_pick < 0 && req_valid[(m_ptr + k) % NREQ]) m_pick = (m_ptr + k) % NREQ;
      if (m_pick >= 0) m_ready[m_pick] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(m_ready));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("alu_run", 32'(alu_run), 32'(m_phase == 1));
      check("resp_valid", 32'(resp_valid), (m_phase == 3) ? (32'd1 << m_grant) : 32'd0);
      if (m_phase == 1) begin
        check("alu_a", 32'(alu_a), 32'(m_op.a));
        check("alu_b", 32'(alu_b), 32'(m_op.b));
        check("alu_select", 32'(alu_select), 32'(m_op.sel));
      end
      case (m_phase)
        0: if (m_pick >= 0) begin
             m_op.a   = req_a[m_pick*W +: W];
             m_op.b   = req_b[m_pick*W +: W];
             m_op.sel = req_sel[m_pick*SW +: SW];
             m_grant  = m_pick;
             m_ptr    = (m_pick + 1) % NREQ;
             exp_q.push_back('{idx: m_pick, data: alu_ref(m_op.a, m_op.b, m_op.sel)});
             m_phase  = 1;
           end
        1: m_phase = 2;
        2: m_phase = 3;
        default: if (resp_ready[m_grant]) m_phase = 0;
      endcase
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  int resp_cnt = 0;
  int r_idx;
  always @(negedge clk) begin
    if (rst) begin
      resp_cnt = 0;
    end else if (resp_valid != '0) begin
      resp_cnt++;
      r_idx = 0;
      for (int i = 0; i < NREQ; i++) if (resp_valid[i]) r_idx = i;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        check("resp_onehot", 32'(resp_valid), 32'd1 << exp_q[0].idx);
        check("resp_data", 32'(resp_data), 32'(exp_q[0].data));
        if ((resp_valid & resp_ready) != '0) begin
          obs_idx.push_back(r_idx);
          obs_data.push_back(resp_data);
          cnt_log.push_back(resp_cnt);
          resp_cnt = 0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver state
  op_t pend[NREQ][$];
  logic [NREQ-1:0] bp_mask = '0;
  bit   rr_mode = 1'b0;
  logic [NREQ-1:0] acc;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i]            = 1'b1;
        req_a[i*W +: W]         = pend[i][0].a;
        req_b[i*W +: W]         = pend[i][0].b;
        req_sel[i*SW +: SW]     = pend[i][0].sel;
      end else begin
        req_valid[i] = 1'b0;
      end
      if (bp_mask[i])   resp_ready[i] = 1'b0;
      else if (rr_mode) resp_ready[i] = 1'($urandom_range(0, 1));
      else              resp_ready[i] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    drive_inputs();
  endtask

  task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] sel);
    pend[i].push_back('{a: a, b: b, sel: sel});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pend[0].size() > 0 || pend[1].size() > 0 || m_phase != 0 || exp_q.size() > 0)
           && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) check({name, "_drain_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, "_alu_run"}, 32'(alu_run), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_alu_a"}, 32'(alu_a), 32'd0);
    check({name, "_alu_b"}, 32'(alu_b), 32'd0);
    check({name, "_alu_select"}, 32'(alu_select), 32'd0);
    check({name, "_resp_data"}, 32'(resp_data), 32'd0);
  endtask

  task automatic do_reset();
    pend[0].delete();
    pend[1].delete();
    req_valid = '0;
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic clear_logs();
    obs_idx.delete();
    obs_data.delete();
    cnt_log.delete();
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  logic [W-1:0] sweep_exp [8] = '{16'h8002, 16'h8000, 16'h0001, 16'h8001,
                                  16'h8000, 16'h0002, 16'h4000, 16'h0001};
  int fair_exp [5] = '{0, 1, 0, 1, 0};
  int nw;

  initial begin
    do_reset();

    // Single op: add 5,3
    clear_logs();
    push_op(0, 16'd5, 16'd3, 3'd0);
    drain("single");
    check("single_count", 32'(obs_idx.size()), 32'd1);
    if (obs_idx.size() > 0) begin
      check("single_idx", 32'(obs_idx[0]), 32'd0);
      check("single_data", 32'(obs_data[0]), 32'd8);
      check("single_latency_cycles", 32'(cnt_log[0]), 32'd1);
    end

    // Contention from reset
    do_reset();
    clear_logs();
    push_op(1, 16'hFF00, 16'h0FF0, 3'd4);
    push_op(0, 16'd10, 16'd4, 3'd1);
    drain("contend");
    check("contend_count", 32'(obs_idx.size()), 32'd2);
    if (obs_idx.size() == 2) begin
      check("contend_idx0", 32'(obs_idx[0]), 32'd0);
      check("contend_data0", 32'(obs_data[0]), 32'd6);
      check("contend_idx1", 32'(obs_idx[1]), 32'd1);
      check("contend_data1", 32'(obs_data[1]), 32'hF0F0);
    end

    // Backpressure: shl 1,4 held with resp_ready0 low for five RESP cycles
    clear_logs();
    bp_mask = 2'b01;
    push_op(0, 16'd1, 16'd4, 3'd5);
    nw = 0;
    do begin
      step();
      nw++;
    end while (!resp_valid[0] && nw < 20);
    check("bp_resp_seen", 32'(resp_valid[0]), 32'd1);
    push_op(1, 16'd7, 16'd2, 3'd1);
    repeat (4) step();
    bp_mask = '0;
    drain("bp");
    check("bp_count", 32'(obs_idx.size()), 32'd2);
    if (obs_idx.size() == 2) begin
      check("bp_data", 32'(obs_data[0]), 32'd16);
      check("bp_hold_cycles", 32'(cnt_log[0]), 32'd6);
      check("bp_second_idx", 32'(obs_idx[1]), 32'd1);
    end

    // Fairness: req0 continuously valid, req1 joins two cycles later
    do_reset();
    clear_logs();
    for (int k = 0; k < 3; k++) push_op(0, W'($urandom), W'($urandom), SW'($urandom_range(0, 4)));
    step();
    step();
    for (int k = 0; k < 2; k++) push_op(1, W'($urandom), W'($urandom), SW'($urandom_range(0, 4)));
    drain("fair");
    check("fair_count", 32'(obs_idx.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < obs_idx.size()) check("fair_grant", 32'(obs_idx[k]), 32'(fair_exp[k]));

    // Mid-op reset during CAPTURE of cmp 3,9
    clear_logs();
    push_op(0, 16'd3, 16'd9, 3'd7);
    nw = 0;
    do begin
      step();
      nw++;
    end while (pend[0].size() > 0 && nw < 20);
    check("midrst_issue", 32'(alu_run), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    push_op(0, 16'd20, 16'd5, 3'd1);
    push_op(1, 16'd6, 16'd6, 3'd7);
    drive_inputs();
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    drain("midrst");
    check("midrst_count", 32'(obs_idx.size()), 32'd2);
    if (obs_idx.size() == 2) begin
      check("midrst_first_idx", 32'(obs_idx[0]), 32'd0);
      check("midrst_first_data", 32'(obs_data[0]), 32'd15);
      check("midrst_second_data", 32'(obs_data[1]), 32'd0);
    end

    // Select sweep through requester 1
    clear_logs();
    for (int s = 0; s < 8; s++) push_op(1, 16'h8001, 16'h0001, SW'(s));
    drain("sweep");
    check("sweep_count", 32'(obs_idx.size()), 32'd8);
    for (int s = 0; s < 8; s++)
      if (s < obs_idx.size()) begin
        check("sweep_idx", 32'(obs_idx[s]), 32'd1);
        check("sweep_data", 32'(obs_data[s]), 32'(sweep_exp[s]));
      end

    // Random traffic with random response backpressure
    clear_logs();
    rr_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [SW-1:0] sel;
      sel = SW'($urandom_range(0, 7));
      push_op(int'($urandom_range(0, NREQ - 1)), W'($urandom),
              (sel == 3'd5 || sel == 3'd6) ? W'($urandom_range(0, 17)) : W'($urandom), sel);
      repeat ($urandom_range(0, 3)) step();
    end
    drain("random");
    rr_mode = 1'b0;
    check("random_count", 32'(obs_idx.size()), 32'd150);

    finish_test();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_fail++;
    finish_test();
  end

endmodule
